// File: rtl/vg8020_ram_pkg.sv
// Shared constants for the VG8020 main-RAM (slot 3) strobe logic.
`timescale 1ns/1ps
package vg8020_ram_pkg;

  // Legal range of the CAS qualification delay, in nclk rising edges
  localparam int unsigned CAS_DELAY_MIN = 1;
  localparam int unsigned CAS_DELAY_MAX = 4;

  // Active-low bus levels
  localparam logic ASSERTED_L = 1'b0;
  localparam logic NEGATED_L  = 1'b1;

  // True when an active-low signal is at its asserted level
  function automatic logic is_asserted_l(input logic sig_l);
    return (sig_l == ASSERTED_L);
  endfunction

endpackage

// File: rtl/vg8020_cas_delay_pipe.sv
// Clear-on-low shift register: arm rises only after req has been high on
// DEPTH consecutive clock edges; any edge with req low empties the pipe.
`timescale 1ns/1ps
module vg8020_cas_delay_pipe
  import vg8020_ram_pkg::*;
#(
  parameter int unsigned DEPTH = CAS_DELAY_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic arm
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  // Next pipe state: stage0 takes req, later stages advance only while req holds
  always_comb begin
    stage_d    = '0;
    stage_d[0] = req;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1] & req;
    end
  end

  // Pipe register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign arm = stage_q[DEPTH-1];

endmodule

// File: rtl/vg8020_ram_cas_gen.sv
// VG8020 slot-3 DRAM /CAS generator.
// /CAS asserts once a qualified slot-3 memory request has persisted for
// CAS_DELAY nclk rising edges and releases combinationally when it ends.
// Optional feature macro: VG8020_CAS_RFSH_INHIBIT_EN adds the nrfsh input and
// blocks /CAS during refresh regardless of the slot select.
`timescale 1ns/1ps
module vg8020_ram_cas_gen
  import vg8020_ram_pkg::*;
#(
  parameter int unsigned CAS_DELAY = 1
) (
  input  logic nclk,
  input  logic nreset,
  input  logic nmreq,
  input  logic nmreqd,
  input  logic nsltsl3,
`ifdef VG8020_CAS_RFSH_INHIBIT_EN
  input  logic nrfsh,
`endif
  output logic ncas
);

  // Reject unsupported delays at elaboration
  if ((CAS_DELAY < CAS_DELAY_MIN) || (CAS_DELAY > CAS_DELAY_MAX)) begin : g_bad_delay
    $fatal(1, "vg8020_ram_cas_gen: CAS_DELAY=%0d outside %0d..%0d",
           CAS_DELAY, CAS_DELAY_MIN, CAS_DELAY_MAX);
  end

  logic req_c;
  logic cas_arm;

  // Qualify: stable memory request to slot 3 (and not a refresh when enabled)
  always_comb begin
    req_c = is_asserted_l(nmreq) & is_asserted_l(nmreqd) & is_asserted_l(nsltsl3);
`ifdef VG8020_CAS_RFSH_INHIBIT_EN
    req_c = req_c & (nrfsh == NEGATED_L);
`endif
  end

  vg8020_cas_delay_pipe #(
    .DEPTH (CAS_DELAY)
  ) u_pipe (
    .clk   (nclk),
    .rst_n (nreset),
    .req   (req_c),
    .arm   (cas_arm)
  );

  // Strobe needs both the armed pipe and the live request; reset forces release
  assign ncas = (cas_arm & req_c & nreset) ? ASSERTED_L : NEGATED_L;

endmodule

// File: tb/tb_vg8020_ram_cas_gen.sv
// Directed bench for vg8020_ram_cas_gen: one instance with CAS_DELAY=1 and
// one with CAS_DELAY=3 driven by the same bus stimulus.
`timescale 1ns/1ps
module tb_vg8020_ram_cas_gen;

  logic nclk;
  logic nreset;
  logic nmreq;
  logic nmreqd;
  logic nsltsl3;
  logic nrfsh;
  logic ncas1;
  logic ncas3;

  int unsigned n_checks;
  int unsigned n_fail;

  vg8020_ram_cas_gen #(.CAS_DELAY(1)) dut1 (
    .nclk    (nclk),
    .nreset  (nreset),
    .nmreq   (nmreq),
    .nmreqd  (nmreqd),
    .nsltsl3 (nsltsl3),
`ifdef VG8020_CAS_RFSH_INHIBIT_EN
    .nrfsh   (nrfsh),
`endif
    .ncas    (ncas1)
  );

  vg8020_ram_cas_gen #(.CAS_DELAY(3)) dut3 (
    .nclk    (nclk),
    .nreset  (nreset),
    .nmreq   (nmreq),
    .nmreqd  (nmreqd),
    .nsltsl3 (nsltsl3),
`ifdef VG8020_CAS_RFSH_INHIBIT_EN
    .nrfsh   (nrfsh),
`endif
    .ncas    (ncas3)
  );

  // 200 ns nclk period, rising edges at 100, 300, 500 ...
  initial nclk = 1'b0;
  always #100 nclk = ~nclk;

  // Hard stop in case the sequence never completes
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic start_req();
    nmreq   = 1'b0;
    nsltsl3 = 1'b0;
    #10 nmreqd = 1'b0;
  endtask

  task automatic end_req();
    nmreq   = 1'b1;
    nsltsl3 = 1'b1;
    #10 nmreqd = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nreset   = 1'b0;
    nmreq    = 1'b0;
    nmreqd   = 1'b0;
    nsltsl3  = 1'b0;
    nrfsh    = 1'b1;

    // Reset with request active
    #5;
    chk("rst_req_d1", ncas1, 1'b1);
    chk("rst_req_d3", ncas3, 1'b1);
    repeat (2) @(posedge nclk);
    #50 chk("rst_hold_d1", ncas1, 1'b1);
    nmreq = 1'b1; nmreqd = 1'b1; nsltsl3 = 1'b1;
    @(negedge nclk) nreset = 1'b1;
    repeat (2) @(posedge nclk);
    #50;
    chk("rst_idle_d1", ncas1, 1'b1);
    chk("rst_idle_d3", ncas3, 1'b1);

    // Read cycle: request starts just after T1, sampled at T2
    @(posedge nclk);
    #1 start_req();
    #20 chk("rd_pre_t2_d1", ncas1, 1'b1);
    @(posedge nclk);
    #75;
    chk("rd_t2_d1", ncas1, 1'b0);
    chk("rd_t2_d3", ncas3, 1'b1);

    // Release at T3 without waiting for an edge, nmreqd still low
    @(posedge nclk);
    #1 nmreq = 1'b1; nsltsl3 = 1'b1;
    #29;
    chk("rel_d1", ncas1, 1'b1);
    chk("rel_d3", ncas3, 1'b1);
    nmreqd = 1'b1;

    // Refresh: nmreq low, slot 3 not selected
    @(posedge nclk);
    #1 nmreq = 1'b0;
    #10 nmreqd = 1'b0;
    #30 chk("rf_a_d1", ncas1, 1'b1);
    @(posedge nclk);
    #50;
    chk("rf_b_d1", ncas1, 1'b1);
    chk("rf_b_d3", ncas3, 1'b1);
    @(posedge nclk);
    #50 chk("rf_c_d1", ncas1, 1'b1);
    // Pipe must still be empty: selecting slot 3 mid-cycle must not strobe yet
    nsltsl3 = 1'b0;
    #1 chk("rf_noglitch_d1", ncas1, 1'b1);
    @(posedge nclk);
    #50 chk("rf_after_d1", ncas1, 1'b0);
    end_req();

`ifdef VG8020_CAS_RFSH_INHIBIT_EN
    // Refresh flagged by nrfsh while slot select is low
    @(posedge nclk);
    #1 nrfsh = 1'b0;
    start_req();
    @(posedge nclk);
    #50 chk("rfsh_a_d1", ncas1, 1'b1);
    @(posedge nclk);
    #50 chk("rfsh_b_d1", ncas1, 1'b1);
    nrfsh = 1'b1;
    #1 chk("rfsh_clr_d1", ncas1, 1'b1);
    end_req();
`endif

    // CAS_DELAY=3: strobe only after the third edge
    @(posedge nclk);
    #1 start_req();
    @(posedge nclk);
    #50;
    chk("d3_e1", ncas3, 1'b1);
    chk("d1_e1", ncas1, 1'b0);
    @(posedge nclk);
    #50 chk("d3_e2", ncas3, 1'b1);
    @(posedge nclk);
    #50 chk("d3_e3", ncas3, 1'b0);
    end_req();

    // Request dropped for one edge after two edges: count restarts
    @(posedge nclk);
    #1 start_req();
    @(posedge nclk);
    #50 chk("d3_r1", ncas3, 1'b1);
    @(posedge nclk);
    #50 chk("d3_r2", ncas3, 1'b1);
    end_req();
    @(posedge nclk);
    #1 start_req();
    @(posedge nclk);
    #50 chk("d3_r4", ncas3, 1'b1);
    @(posedge nclk);
    #50 chk("d3_r5", ncas3, 1'b1);
    @(posedge nclk);
    #50;
    chk("d3_r6", ncas3, 1'b0);
    chk("d1_r6", ncas1, 1'b0);

    // Mid-cycle reset with request held
    #20 nreset = 1'b0;
    #1;
    chk("mr_d1", ncas1, 1'b1);
    chk("mr_d3", ncas3, 1'b1);
    @(posedge nclk);
    #50 chk("mr_hold_d1", ncas1, 1'b1);
    @(negedge nclk) nreset = 1'b1;
    #10 chk("mr_rel_d1", ncas1, 1'b1);
    @(posedge nclk);
    #50;
    chk("mr_e1_d1", ncas1, 1'b0);
    chk("mr_e1_d3", ncas3, 1'b1);
    @(posedge nclk);
    #50 chk("mr_e2_d3", ncas3, 1'b1);
    @(posedge nclk);
    #50 chk("mr_e3_d3", ncas3, 1'b0);
    end_req();
    #20;
    chk("end_d1", ncas1, 1'b1);
    chk("end_d3", ncas3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
